ball_engine: RTL and testbench
==============================

# ball_engine

Parameterised pong-ball engine that replaces the fixed-size ball controller/datapath pair. It tracks one SIZE×SIZE ball inside a configurable playfield and moves it on a programmable frame divider. It bounces off the side walls and the two paddles, and detects goals, then re-serves after a delay. Every erase and redraw goes out as a pixel stream over a valid/ready handshake to the shared VGA write arbiter.

## Interface
- X_W, 8: x coordinate width
- Y_W, 7: y coordinate width
- SIZE, 4: ball edge in pixels (2..8)
- X_MIN, 51 / X_MAX, 108: left wall column / right wall column (exclusive)
- Y_TOP, 12 / Y_BOT, 106: top paddle row / bottom paddle row
- PAD_W, 16: paddle width in pixels
- START_X, 80 / START_Y, 60: serve position
- SERVE_TICKS, 60: ticks the ball waits after a goal
- HIDE_PERIOD, 5: in hide mode, every HIDE_PERIOD-th draw is invisible
- clk  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- tick  in  1  one-cycle frame pulse
- speed  in  4  ball moves once every speed+1 accepted ticks
- hide_en  in  1  hide-mode enable
- pad_bot_x, pad_top_x  in  X_W  left column of the bottom and top paddles
- pix_valid  out  1  pixel request
- pix_ready  in  1  arbiter accepts pixel
- pix_x  out  X_W, pix_y  out  Y_W, pix_color  out  3  pixel payload
- score_top, score_bot  out  1  one-cycle goal pulse (top player / bottom player scored)
- ball_x  out  X_W, ball_y  out  Y_W  top-left corner of the ball
- dir_x, dir_y  out  1  1 = +x (right) / +y (down)
- busy  out  1  high in ERASE, MOVE, DRAW

## Operation
- Reset values (async): state IDLE, ball_x=START_X, ball_y=START_Y, dir_x=1, dir_y=1, frame_cnt=0, serve_cnt=0, draw_cnt=0, colour=4, pix_valid=0, scores=0, busy=0.
- IDLE: a tick increments frame_cnt. When frame_cnt >= speed on a tick, frame_cnt clears and the FSM enters ERASE. A live speed change takes effect on the next tick.
- ERASE: the block streams SIZE² pixels of colour 0 at (ball_x+c, ball_y+r) in row-major order, column fastest. When the last pixel is accepted, the FSM enters MOVE.
- MOVE is a single cycle. Reflections are evaluated on the current position first, then the ball steps ±1 in x and y using the updated directions.
  - Wall reflection: dir_x=1 and ball_x+SIZE >= X_MAX sets dir_x=0. dir_x=0 and ball_x <= X_MIN sets dir_x=1.
  - Paddle overlap: ball_x+SIZE > pad_x and ball_x < pad_x+PAD_W. All sums are computed at X_W+1 or Y_W+1 bits with no wrap.
  - Bottom contact: dir_y=1 and ball_y+SIZE == Y_BOT. With overlap, dir_y=0. Without overlap, it is a goal: score_top pulses.
  - Top contact: dir_y=0 and ball_y == Y_TOP+1. With overlap, dir_y=1. Without overlap, it is a goal: score_bot pulses.
  - Goal: position reloads to START, dir_y inverts, dir_x is kept, and no step is taken.
  - A simultaneous wall and paddle contact applies both reflections.
- DRAW: the block streams SIZE² pixels. Pixels with r==0 or c==0 get colour 0 (gap border); all others get the colour register.
  - If hide_en=1 and draw_cnt == HIDE_PERIOD-1, every pixel gets colour 0.
  - After the last pixel, draw_cnt wraps modulo HIDE_PERIOD and colour advances 4→5→6→7→4.
  - The next state is SERVE if a goal occurred in this round, otherwise IDLE.
- SERVE: the block counts SERVE_TICKS ticks, then returns to IDLE with frame_cnt=0.
- Ticks arriving in ERASE, MOVE or DRAW are dropped.

## Timing
- Handshake: pix_valid rises with the payload valid. Payload is held stable until pix_valid & pix_ready. The next pixel is presented in the cycle after acceptance, or back-to-back when pix_ready stays high. pix_valid never drops without acceptance.
- Trigger tick at cycle T: ERASE is entered and the first pix_valid appears at T+1.
- With pix_ready tied to 1, a round takes SIZE² + 1 + SIZE² cycles (33 for SIZE=4) from the first pix_valid to the return to IDLE/SERVE.
- ball_x, ball_y, dir_x and dir_y update on the MOVE clock edge. score_* is high exactly in the cycle after MOVE.
- Reset asserted mid-stream drops pix_valid immediately. A partially erased ball is not restored.

## Test plan
- Free run, speed=0, pix_ready=1, defaults: the first tick produces 16 erase pixels at (80..83, 60..63), then ball=(81,61), then 16 draw pixels with 9 at colour 4. The next round uses colour 5.
- speed=3: a move occurs only on every 4th tick. Ticks asserted during busy do not advance frame_cnt.
- Ball at x=104, dir_x=1: MOVE gives dir_x=0, ball_x=103. Ball at x=51, dir_x=0: MOVE gives dir_x=1, ball_x=52.
- Ball at y=102, dir_y=1, pad_bot_x=ball_x-2: bounce, y=101. With pad_bot_x=ball_x+4 instead: score_top pulses for 1 cycle, ball returns to (80,60), dir_y=0, then a SERVE of 60 ticks with no movement.
- pix_ready randomly throttled: the payload holds stable while stalled, all 32 pixels are delivered exactly once, and order is row-major.
- hide_en=1: in every 5th DRAW all pixels are colour 0. Reset asserted mid-ERASE: pix_valid=0 and all outputs return to their reset values immediately.

Source files
------------

// File: rtl/ball_engine.sv
// ball_engine
// Pong-ball engine. It tracks one SIZE x SIZE ball inside a playfield that
// has side walls and a paddle at the top and bottom. The ball moves once every
// speed+1 accepted frame ticks. It bounces off the walls and the paddles,
// detects goals and re-serves the ball after SERVE_TICKS ticks. Every erase and
// every redraw of the ball goes out as a row-major pixel stream over a
// valid/ready handshake.
//
// Ports
//   clk, resetn            system clock, asynchronous active-low reset
//   tick                   one-cycle frame pulse
//   speed[3:0]             ball moves once every speed+1 accepted ticks
//   hide_en                every HIDE_PERIOD-th draw is invisible
//   pad_bot_x, pad_top_x   left column of the bottom and top paddles
//   pix_valid/pix_ready    pixel handshake to the VGA write arbiter
//   pix_x, pix_y, pix_color pixel payload
//   score_top, score_bot   one-cycle goal pulses
//   ball_x, ball_y         top-left corner of the ball
//   dir_x, dir_y           1 = moving right / down
//   busy                   high while ERASE, MOVE or DRAW is in progress
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for ticks, frame divider counts accepted ticks
// ERASE | stream SIZE*SIZE colour-0 pixels over the old ball position
// MOVE  | one cycle: apply wall/paddle reflections, detect goal, step
// DRAW  | stream SIZE*SIZE pixels of the ball at its new position
// SERVE | after a goal, wait SERVE_TICKS ticks before play resumes

module ball_engine #(
   parameter int X_W         = 8,
   parameter int Y_W         = 7,
   parameter int SIZE        = 4,
   parameter int X_MIN       = 51,
   parameter int X_MAX       = 108,
   parameter int Y_TOP       = 12,
   parameter int Y_BOT       = 106,
   parameter int PAD_W       = 16,
   parameter int START_X     = 80,
   parameter int START_Y     = 60,
   parameter int SERVE_TICKS = 60,
   parameter int HIDE_PERIOD = 5
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           tick,
   input  logic [3:0]     speed,
   input  logic           hide_en,
   input  logic [X_W-1:0] pad_bot_x,
   input  logic [X_W-1:0] pad_top_x,
   output logic           pix_valid,
   input  logic           pix_ready,
   output logic [X_W-1:0] pix_x,
   output logic [Y_W-1:0] pix_y,
   output logic [2:0]     pix_color,
   output logic           score_top,
   output logic           score_bot,
   output logic [X_W-1:0] ball_x,
   output logic [Y_W-1:0] ball_y,
   output logic           dir_x,
   output logic           dir_y,
   output logic           busy
);

   localparam int CW  = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam int SCW = $clog2(SERVE_TICKS + 1);
   localparam int DCW = (HIDE_PERIOD > 1) ? $clog2(HIDE_PERIOD) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ERASE,
      S_MOVE,
      S_DRAW,
      S_SERVE
   } state_t;

   state_t         r_state;
   logic [X_W-1:0] r_ball_x;
   logic [Y_W-1:0] r_ball_y;
   logic           r_dir_x;
   logic           r_dir_y;
   logic [3:0]     r_frame_cnt;
   logic [SCW-1:0] r_serve_cnt;
   logic [DCW-1:0] r_draw_cnt;
   logic [2:0]     r_colour;
   logic           r_goal;
   logic [CW-1:0]  r_row;
   logic [CW-1:0]  r_col;
   logic           r_pix_valid;
   logic [X_W-1:0] r_pix_x;
   logic [Y_W-1:0] r_pix_y;
   logic [2:0]     r_pix_color;
   logic           r_score_top;
   logic           r_score_bot;
   logic           r_busy;

   // Position sums are one bit wider than the coordinates so they never wrap.
   logic [X_W:0]   w_bx;
   logic [X_W:0]   w_bx_sum;
   logic [Y_W:0]   w_by;
   logic [Y_W:0]   w_by_sum;
   logic           w_ovl_bot;
   logic           w_ovl_top;
   logic           w_hit_bot;
   logic           w_hit_top;
   logic           w_nx_dir_x;
   logic           w_nx_dir_y;
   logic           w_goal_top;
   logic           w_goal_bot;
   logic [X_W-1:0] w_nx_x;
   logic [Y_W-1:0] w_nx_y;
   logic           w_acc;
   logic           w_last;
   logic [CW-1:0]  w_nrow;
   logic [CW-1:0]  w_ncol;
   logic           w_hide;
   logic [X_W-1:0] w_base_x;
   logic [Y_W-1:0] w_base_y;

   assign w_bx      = {1'b0, r_ball_x};
   assign w_by      = {1'b0, r_ball_y};
   assign w_bx_sum  = w_bx + (X_W+1)'(SIZE);
   assign w_by_sum  = w_by + (Y_W+1)'(SIZE);
   assign w_ovl_bot = (w_bx_sum > {1'b0, pad_bot_x}) &&
                      (w_bx < ({1'b0, pad_bot_x} + (X_W+1)'(PAD_W)));
   assign w_ovl_top = (w_bx_sum > {1'b0, pad_top_x}) &&
                      (w_bx < ({1'b0, pad_top_x} + (X_W+1)'(PAD_W)));
   assign w_hit_bot = r_dir_y && (w_by_sum == (Y_W+1)'(Y_BOT));
   assign w_hit_top = !r_dir_y && (w_by == (Y_W+1)'(Y_TOP + 1));

   always_comb begin
      w_nx_dir_x = r_dir_x;
      w_nx_dir_y = r_dir_y;
      w_goal_top = 1'b0;
      w_goal_bot = 1'b0;
      if (r_dir_x && (w_bx_sum >= (X_W+1)'(X_MAX)))
         w_nx_dir_x = 1'b0;
      else if (!r_dir_x && (w_bx <= (X_W+1)'(X_MIN)))
         w_nx_dir_x = 1'b1;
      if (w_hit_bot) begin
         if (w_ovl_bot) w_nx_dir_y = 1'b0;
         else           w_goal_top = 1'b1;
      end
      if (w_hit_top) begin
         if (w_ovl_top) w_nx_dir_y = 1'b1;
         else           w_goal_bot = 1'b1;
      end
      // A goal re-serves from the start point, flips vertical direction and
      // takes no step this round.
      if (w_goal_top || w_goal_bot) begin
         w_nx_x     = X_W'(START_X);
         w_nx_y     = Y_W'(START_Y);
         w_nx_dir_y = ~r_dir_y;
      end else begin
         w_nx_x = w_nx_dir_x ? r_ball_x + X_W'(1) : r_ball_x - X_W'(1);
         w_nx_y = w_nx_dir_y ? r_ball_y + Y_W'(1) : r_ball_y - Y_W'(1);
      end
   end

   assign w_acc    = r_pix_valid & pix_ready;
   assign w_last   = (r_row == CW'(SIZE - 1)) && (r_col == CW'(SIZE - 1));
   assign w_ncol   = (r_col == CW'(SIZE - 1)) ? '0 : r_col + CW'(1);
   assign w_nrow   = (r_col == CW'(SIZE - 1)) ? r_row + CW'(1) : r_row;
   assign w_hide   = hide_en && (r_draw_cnt == DCW'(HIDE_PERIOD - 1));
   assign w_base_x = r_ball_x + X_W'(w_ncol);
   assign w_base_y = r_ball_y + Y_W'(w_nrow);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_ball_x    <= X_W'(START_X);
         r_ball_y    <= Y_W'(START_Y);
         r_dir_x     <= 1'b1;
         r_dir_y     <= 1'b1;
         r_frame_cnt <= '0;
         r_serve_cnt <= '0;
         r_draw_cnt  <= '0;
         r_colour    <= 3'd4;
         r_goal      <= 1'b0;
         r_row       <= '0;
         r_col       <= '0;
         r_pix_valid <= 1'b0;
         r_pix_x     <= '0;
         r_pix_y     <= '0;
         r_pix_color <= '0;
         r_score_top <= 1'b0;
         r_score_bot <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_score_top <= 1'b0;
         r_score_bot <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (tick) begin
                  if (r_frame_cnt >= speed) begin
                     r_frame_cnt <= '0;
                     r_state     <= S_ERASE;
                     r_busy      <= 1'b1;
                     r_pix_valid <= 1'b1;
                     r_row       <= '0;
                     r_col       <= '0;
                     r_pix_x     <= r_ball_x;
                     r_pix_y     <= r_ball_y;
                     r_pix_color <= 3'd0;
                  end else begin
                     r_frame_cnt <= r_frame_cnt + 4'd1;
                  end
               end
            end
            S_ERASE: begin
               if (w_acc) begin
                  if (w_last) begin
                     r_pix_valid <= 1'b0;
                     r_state     <= S_MOVE;
                  end else begin
                     r_row   <= w_nrow;
                     r_col   <= w_ncol;
                     r_pix_x <= w_base_x;
                     r_pix_y <= w_base_y;
                  end
               end
            end
            S_MOVE: begin
               r_ball_x    <= w_nx_x;
               r_ball_y    <= w_nx_y;
               r_dir_x     <= w_nx_dir_x;
               r_dir_y     <= w_nx_dir_y;
               r_goal      <= w_goal_top | w_goal_bot;
               r_score_top <= w_goal_top;
               r_score_bot <= w_goal_bot;
               r_state     <= S_DRAW;
               r_pix_valid <= 1'b1;
               r_row       <= '0;
               r_col       <= '0;
               r_pix_x     <= w_nx_x;
               r_pix_y     <= w_nx_y;
               r_pix_color <= 3'd0;
            end
            S_DRAW: begin
               if (w_acc) begin
                  if (w_last) begin
                     r_pix_valid <= 1'b0;
                     r_busy      <= 1'b0;
                     r_draw_cnt  <= (r_draw_cnt == DCW'(HIDE_PERIOD - 1)) ?
                                    '0 : r_draw_cnt + DCW'(1);
                     r_colour    <= (r_colour == 3'd7) ? 3'd4 : r_colour + 3'd1;
                     if (r_goal) begin
                        r_state     <= S_SERVE;
                        r_serve_cnt <= SCW'(SERVE_TICKS);
                        r_goal      <= 1'b0;
                     end else begin
                        r_state <= S_IDLE;
                     end
                  end else begin
                     r_row       <= w_nrow;
                     r_col       <= w_ncol;
                     r_pix_x     <= w_base_x;
                     r_pix_y     <= w_base_y;
                     // Row 0 and column 0 form the gap border around the ball.
                     r_pix_color <= (w_hide || (w_nrow == '0) || (w_ncol == '0)) ?
                                    3'd0 : r_colour;
                  end
               end
            end
            S_SERVE: begin
               if (tick) begin
                  if (r_serve_cnt <= SCW'(1)) begin
                     r_serve_cnt <= '0;
                     r_frame_cnt <= '0;
                     r_state     <= S_IDLE;
                  end else begin
                     r_serve_cnt <= r_serve_cnt - SCW'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign pix_valid = r_pix_valid;
   assign pix_x     = r_pix_x;
   assign pix_y     = r_pix_y;
   assign pix_color = r_pix_color;
   assign score_top = r_score_top;
   assign score_bot = r_score_bot;
   assign ball_x    = r_ball_x;
   assign ball_y    = r_ball_y;
   assign dir_x     = r_dir_x;
   assign dir_y     = r_dir_y;
   assign busy      = r_busy;

endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine
// Self-checking bench for ball_engine with default parameters. A behavioural
// ball model predicts every erase/draw pixel and pushes it to a queue when a
// round is triggered; a monitor pops and compares on each accepted pixel.

module tb_ball_engine;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       tick = 1'b0;
   logic [3:0] speed = 4'd0;
   logic       hide_en = 1'b0;
   logic [7:0] pad_bot_x = 8'd0;
   logic [7:0] pad_top_x = 8'd0;
   logic       pix_valid;
   logic       pix_ready = 1'b1;
   logic [7:0] pix_x;
   logic [6:0] pix_y;
   logic [2:0] pix_color;
   logic       score_top;
   logic       score_bot;
   logic [7:0] ball_x;
   logic [6:0] ball_y;
   logic       dir_x;
   logic       dir_y;
   logic       busy;

   ball_engine dut (
      .clk       (clk),
      .resetn    (resetn),
      .tick      (tick),
      .speed     (speed),
      .hide_en   (hide_en),
      .pad_bot_x (pad_bot_x),
      .pad_top_x (pad_top_x),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .pix_color (pix_color),
      .score_top (score_top),
      .score_bot (score_bot),
      .ball_x    (ball_x),
      .ball_y    (ball_y),
      .dir_x     (dir_x),
      .dir_y     (dir_y),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   int exp_q[$];
   bit throttle = 1'b0;
   bit skip_mon = 1'b0;
   int n_pix = 0;
   int n_st = 0;
   int n_sb = 0;
   int bot_hits = 0;

   int mx, my, mdx, mdy, mcol, mdraw;

   function automatic int pk(input int x, input int y, input int c);
      return (x << 10) | (y << 3) | c;
   endfunction

   function automatic void model_reset();
      mx = 80; my = 60; mdx = 1; mdy = 1; mcol = 4; mdraw = 0;
   endfunction

   task automatic model_round(output bit gt, output bit gb);
      int ndx, ndy, ob, ot, c;
      bit hide;
      for (int r = 0; r < 4; r++)
         for (int cc = 0; cc < 4; cc++)
            exp_q.push_back(pk(mx + cc, my + r, 0));
      ndx = mdx; ndy = mdy; gt = 0; gb = 0;
      if (mdx == 1 && mx + 4 >= 108) ndx = 0;
      else if (mdx == 0 && mx <= 51) ndx = 1;
      ob = (mx + 4 > int'(pad_bot_x)) && (mx < int'(pad_bot_x) + 16);
      ot = (mx + 4 > int'(pad_top_x)) && (mx < int'(pad_top_x) + 16);
      if (mdy == 1 && my + 4 == 106) begin
         if (ob != 0) ndy = 0; else gt = 1;
      end else if (mdy == 0 && my == 13) begin
         if (ot != 0) ndy = 1; else gb = 1;
      end
      if (gt || gb) begin
         mx = 80; my = 60; mdy = 1 - mdy; mdx = ndx;
      end else begin
         mx = mx + (ndx != 0 ? 1 : -1);
         my = my + (ndy != 0 ? 1 : -1);
         mdx = ndx; mdy = ndy;
      end
      hide = hide_en && (mdraw == 4);
      for (int r = 0; r < 4; r++)
         for (int cc = 0; cc < 4; cc++) begin
            c = (hide || r == 0 || cc == 0) ? 0 : mcol;
            exp_q.push_back(pk(mx + cc, my + r, c));
         end
      mdraw = (mdraw + 1) % 5;
      mcol = (mcol == 7) ? 4 : mcol + 1;
   endtask

   // Monitor: hold check, ready throttling, scoreboard pop, score pulse count.
   initial begin
      bit pv;
      bit pr;
      int pp;
      int cur;
      pv = 0; pr = 1; pp = 0;
      forever begin
         @(negedge clk);
         cur = int'({pix_x, pix_y, pix_color});
         if (!resetn) begin
            pv = 0;
         end else begin
            if (pv && !pr) begin
               check("hold_valid", pix_valid, 1);
               check("hold_payload", cur, pp);
            end
            pix_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pix_valid && pix_ready) begin
               n_pix++;
               if (!skip_mon) begin
                  if (exp_q.size() == 0) check("unexpected_pixel", cur, -1);
                  else                   check("pix", cur, exp_q.pop_front());
               end
            end
            pv = pix_valid; pr = pix_ready; pp = cur;
            if (score_top) n_st++;
            if (score_bot) n_sb++;
         end
      end
   end

   task automatic send_tick();
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
   endtask

   task automatic run_round(input bit extra);
      bit gt, gb;
      int st0, sb0, cnt, p0;
      if (mdy == 1 && my + 4 == 106) begin
         bot_hits++;
         pad_bot_x = (bot_hits == 1) ? 8'(mx + 4) : 8'(mx - 15);
      end
      if (mdy == 0 && my == 13) pad_top_x = 8'(mx + 3);
      st0 = n_st; sb0 = n_sb;
      model_round(gt, gb);
      send_tick();
      check("first_valid", pix_valid, 1);
      cnt = busy ? 1 : 0;
      if (extra) begin
         tick = 1'b1;
         @(negedge clk) tick = 1'b0;
         if (busy) cnt++;
      end
      while (busy && cnt < 3000) begin
         @(negedge clk);
         if (busy) cnt++;
      end
      @(negedge clk);
      check("round_done", int'(cnt < 3000), 1);
      if (!throttle) check("round_len", cnt, 33);
      check("queue_empty", exp_q.size(), 0);
      check("ball_x", ball_x, mx);
      check("ball_y", ball_y, my);
      check("dir_x", dir_x, mdx);
      check("dir_y", dir_y, mdy);
      check("score_top", n_st - st0, int'(gt));
      check("score_bot", n_sb - sb0, int'(gb));
      if (gt || gb) begin
         p0 = n_pix;
         check("serve_busy", busy, 0);
         repeat (59) send_tick();
         check("serve_wait_pix", n_pix, p0);
         check("serve_wait_x", ball_x, 80);
         send_tick();
         check("serve_end_pix", n_pix, p0);
      end
   endtask

   initial begin
      model_reset();
      hide_en = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_ball_x", ball_x, 80);
      check("rst_ball_y", ball_y, 60);
      check("rst_dir_x", dir_x, 1);
      check("rst_dir_y", dir_y, 1);
      check("rst_valid", pix_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_score", int'(score_top | score_bot), 0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      run_round(0);
      run_round(0);

      speed = 4'd3;
      repeat (3) begin
         send_tick();
         check("speed_wait", busy, 0);
      end
      run_round(1);
      repeat (3) begin
         send_tick();
         check("speed_drop", busy, 0);
      end
      run_round(0);
      speed = 4'd0;

      throttle = 1'b1;
      repeat (10) run_round(0);
      throttle = 1'b0;
      @(negedge clk);

      for (int r = 0; r < 400 && bot_hits < 2; r++) run_round(0);
      run_round(0);

      // Reset in the middle of an erase stream.
      skip_mon = 1'b1;
      send_tick();
      repeat (3) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      check("mid_rst_valid", pix_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_x", ball_x, 80);
      check("mid_rst_y", ball_y, 60);
      check("mid_rst_dir_x", dir_x, 1);
      check("mid_rst_dir_y", dir_y, 1);
      @(negedge clk);
      resetn = 1'b1;
      exp_q.delete();
      model_reset();
      skip_mon = 1'b0;
      pad_bot_x = 8'd0;
      pad_top_x = 8'd0;
      repeat (2) @(negedge clk);
      run_round(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
